alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares the single 8-bit ALU among N_REQ requesters.
//   Typical requesters: control FSM, stack/IO helper, debug port.
//   Each request is an {opcode, a, b} transaction. The block latches the winner's operands,
//   drives the combinational ALU for one cycle, captures result + flags, and returns them over
//   a valid/ready response handshake. Sits between requesters and the ALU; ALU ports connect 1:1.
// PARAMETERS
//   N_REQ   4   number of requesters (2..8)
//   DATA_W  8   operand/result width
//   OP_W    8   opcode width (ALU opcode encoding: 0x00 ADD .. 0x14 NOT, 0xFF NOP)
// PORTS
//   clk          in   1            clock, rising edge
//   reset        in   1            asynchronous, active-high
//   req_valid    in   N_REQ        per-requester request valid
//   req_ready    out  N_REQ        per-requester accept (one-hot, at most one bit set)
//   req_opcode   in   N_REQ*OP_W   packed opcodes, requester i at [i*OP_W +: OP_W]
//   req_a        in   N_REQ*DATA_W packed operand A
//   req_b        in   N_REQ*DATA_W packed operand B
//   rsp_valid    out  N_REQ        one-hot response valid to the requester that was granted
//   rsp_ready    in   N_REQ        per-requester response accept
//   rsp_result   out  DATA_W       result, shared bus, meaningful while any rsp_valid is set
//   rsp_flags    out  5            {overflow, parity, sign, carry, zero}, captured from ALU
//   rsp_err      out  1            1 = DIV/MOD by zero, operation suppressed
//   alu_opcode   out  OP_W         to ALU; 0xFF (NOP) except in EXEC
//   alu_a        out  DATA_W       to ALU operand A
//   alu_b        out  DATA_W       to ALU operand B
//   alu_result   in   DATA_W       from ALU (combinational)
//   alu_flags    in   5            from ALU, same order as rsp_flags
//   busy         out  1            1 in any state but IDLE
//   grant_id     out  3            index of current/last granted requester
// BEHAVIOUR
//   Reset values:
//     - State = IDLE; req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, busy = 0.
//     - alu_opcode = 0xFF; alu_a, alu_b = 0; grant_id = 0.
//     - Round-robin pointer rr_ptr = N_REQ-1, so requester 0 has first priority.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     - Winner = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
//     - req_ready[winner] is asserted combinationally in the same cycle; no other ready bit is set.
//     - On that edge: latch opcode, a, b and winner into internal registers; grant_id <= winner;
//       rr_ptr <= winner; go to EXEC.
//     - No req_valid set: stay in IDLE, all ready bits 0.
//   EXEC (exactly 1 cycle):
//     - Drive alu_opcode/a/b from the latched registers.
//     - At the clock edge, capture alu_result -> rsp_result and alu_flags -> rsp_flags; go to RESP.
//     - Divide-by-zero: if opcode is 0x03 or 0x04 and b == 0, alu_opcode stays 0xFF.
//       Capture rsp_result = 0xFF, rsp_flags = 0, rsp_err = 1. Otherwise rsp_err = 0.
//   RESP:
//     - rsp_valid[grant_id] = 1. Result, flags and err are held stable until
//       rsp_valid & rsp_ready for grant_id; then go to IDLE.
//     - rsp_ready of other requesters is ignored.
//     - New requests are not accepted during EXEC/RESP; req_ready = 0.
//   Timing:
//     - Latency: accept edge T, rsp_valid high in cycle T+2 (counted from the cycle after T).
//     - Peak throughput: 1 op per 3 cycles with rsp_ready tied high.
//   Requester rules:
//     - A requester must hold req_valid and operands stable until req_ready.
//     - Dropping req_valid before grant is legal and loses no state.
//   Fairness:
//     - With all requesters continuously valid, grants rotate 0,1,2,...,N_REQ-1,0.
//     - No requester waits more than N_REQ-1 other grants.
//   Other rules:
//     - Unknown opcodes pass through to the ALU unchanged; the ALU returns its NOP result.
//     - Reset mid-operation (any state): return to IDLE in the same cycle (async).
//       The in-flight transaction is discarded and no rsp_valid is ever issued for it.
// TESTING
//   1. Single req: req0 ADD a=0x7F b=0x01 -> rsp_valid[0] 2 cycles after accept;
//      result 0x80; flags overflow=1, sign=1, zero=0, carry=0.
//   2. All 4 valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0; req_ready one-hot every accept.
//   3. DIV a=0x10 b=0x00 from req2 -> alu_opcode never leaves 0xFF;
//      rsp_result 0xFF, rsp_err=1, rsp_valid[2] only.
//   4. Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1], result, flags stable;
//      req_ready stays 0 for all requesters; release -> IDLE next cycle.
//   5. Async reset asserted in EXEC -> busy=0 and alu_opcode=0xFF immediately;
//      no rsp_valid after release; next grant goes to req0.
//   6. ADD 0xFF+0x01 from req3 while req1 drops req_valid before grant ->
//      req3 granted, result 0x00, zero=1, carry=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among N_REQ requesters.
// Accepts one {opcode, a, b} transaction, runs it through the ALU for one cycle and returns the result.
module alu_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*OP_W-1:0]    req_opcode,
  input  logic [N_REQ*DATA_W-1:0]  req_a,
  input  logic [N_REQ*DATA_W-1:0]  req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic [4:0]               rsp_flags,
  output logic                     rsp_err,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [4:0]               alu_flags,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic [1:0]               dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [OP_W-1:0] OP_NOP = '1;
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, gnt_q;
  logic [OP_W-1:0]      op_q;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [DATA_W-1:0]    result_q;
  logic [4:0]           flags_q;
  logic                 err_q;

  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     idx;
  logic                 div0;

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response completes on the edge where rsp_valid[g] & rsp_ready[g] for the granted g.

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign div0 = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && found) begin
        op_q     <= req_opcode[int'(win)*OP_W +: OP_W];
        a_q      <= req_a[int'(win)*DATA_W +: DATA_W];
        b_q      <= req_b[int'(win)*DATA_W +: DATA_W];
        gnt_q    <= win;
        rr_ptr_q <= win;
      end
      if (state_q == EXEC) begin
        // A zero divisor never reaches the ALU; the response is a fixed error pattern.
        if (div0) begin
          result_q <= '1;
          flags_q  <= '0;
          err_q    <= 1'b1;
        end else begin
          result_q <= alu_result;
          flags_q  <= alu_flags;
          err_q    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && found) req_ready[win] = 1'b1;
    if (state_q == RESP) rsp_valid[gnt_q] = 1'b1;
  end

  assign alu_opcode = (state_q == EXEC && !div0) ? op_q : OP_NOP;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = 3'(gnt_q);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the shared ALU port.
module tb_alu_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 8;
  localparam int W  = 14;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_opcode = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '1;
  logic [DW-1:0]   rsp_result;
  logic [4:0]      rsp_flags;
  logic            rsp_err;
  logic [OW-1:0]   alu_opcode;
  logic [DW-1:0]   alu_a, alu_b;
  logic [DW-1:0]   alu_result;
  logic [4:0]      alu_flags;
  logic            busy;
  logic [2:0]      grant_id;
  logic [1:0]      dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  alu_share_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // ALU model: ADD, DIV, MOD; flags {overflow, parity(odd), sign, carry, zero}
  logic [8:0] sum9;
  logic [7:0] m_res;
  logic       m_c, m_v;
  always_comb begin
    sum9  = '0;
    m_res = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_opcode)
      8'h00: begin
        sum9  = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = sum9[7:0];
        m_c   = sum9[8];
        m_v   = (alu_a[7] == alu_b[7]) && (m_res[7] != alu_a[7]);
      end
      8'h03: m_res = (alu_b != 8'h00) ? alu_a / alu_b : 8'h00;
      8'h04: m_res = (alu_b != 8'h00) ? alu_a % alu_b : 8'h00;
      default: m_res = 8'h00;
    endcase
    alu_result = m_res;
    alu_flags  = (alu_opcode == 8'hFF) ? 5'b0 : {m_v, ^m_res, m_res[7], m_c, (m_res == 8'h00)};
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[id*OW +: OW] = op;
    req_a[id*DW +: DW]      = a;
    req_b[id*DW +: DW]      = b;
  endtask

  // Runs one transaction from the IDLE cycle where req_valid[id] is already presented.
  task automatic run_txn(input int id, input logic [7:0] exec_op, input logic [7:0] a,
                         input logic [7:0] b, input bit drop, input logic [N-1:0] raise,
                         input int hold);
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    exp_v = '0;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(1 << id));
    chk("alu_opcode_idle", 32'(alu_opcode), 32'hFF);
    tick();
    if (drop) req_valid[id] = 1'b0;
    req_valid = req_valid | raise;
    chk("busy_exec", 32'(busy), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    chk("alu_opcode_exec", 32'(alu_opcode), 32'(exec_op));
    chk("alu_a_exec", 32'(alu_a), 32'(a));
    chk("alu_b_exec", 32'(alu_b), 32'(b));
    tick();
    chk("rsp_valid_resp", 32'(rsp_valid), 32'(1 << id));
    chk("alu_opcode_resp", 32'(alu_opcode), 32'hFF);
    got = {rsp_err, rsp_flags, rsp_result};
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      chk("rsp_payload", 32'(got), 32'(exp_v));
    end
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(1 << id));
      chk("hold_payload", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp_v));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    if (hold > 0) rsp_ready = '1;
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_payload", 32'({rsp_err, rsp_flags, rsp_result}), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'hFF);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // single request: 0x7F + 0x01 -> 0x80, overflow/parity/sign set
    set_ops(0, 8'h00, 8'h7F, 8'h01);
    req_valid[0] = 1'b1;
    exp_q.push_back({1'b0, 5'b11100, 8'h80});
    run_txn(0, 8'h00, 8'h7F, 8'h01, 1'b1, '0, 0);

    // fresh reset, all four valid: grants 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ops(0, 8'h00, 8'h01, 8'h02);
    set_ops(1, 8'h00, 8'h80, 8'h80);
    set_ops(2, 8'h03, 8'h10, 8'h04);
    set_ops(3, 8'h04, 8'h11, 8'h05);
    req_valid = 4'b1111;
    exp_q.push_back({1'b0, 5'b00000, 8'h03});
    exp_q.push_back({1'b0, 5'b10011, 8'h00});
    exp_q.push_back({1'b0, 5'b01000, 8'h04});
    exp_q.push_back({1'b0, 5'b01000, 8'h02});
    exp_q.push_back({1'b0, 5'b00000, 8'h03});
    run_txn(0, 8'h00, 8'h01, 8'h02, 1'b0, '0, 0);
    run_txn(1, 8'h00, 8'h80, 8'h80, 1'b0, '0, 0);
    run_txn(2, 8'h03, 8'h10, 8'h04, 1'b0, '0, 0);
    run_txn(3, 8'h04, 8'h11, 8'h05, 1'b0, '0, 0);
    run_txn(0, 8'h00, 8'h01, 8'h02, 1'b0, '0, 0);
    req_valid = '0;

    // divide by zero from req2: ALU never sees the opcode
    set_ops(2, 8'h03, 8'h10, 8'h00);
    req_valid[2] = 1'b1;
    exp_q.push_back({1'b1, 5'b00000, 8'hFF});
    run_txn(2, 8'hFF, 8'h10, 8'h00, 1'b1, '0, 0);

    // backpressure on req1 for 5 cycles while req0/req3 wait
    set_ops(1, 8'h00, 8'h05, 8'h03);
    set_ops(0, 8'h00, 8'h33, 8'h44);
    set_ops(3, 8'h00, 8'h55, 8'h66);
    req_valid[1] = 1'b1;
    rsp_ready = 4'b1101;
    exp_q.push_back({1'b0, 5'b01000, 8'h08});
    run_txn(1, 8'h00, 8'h05, 8'h03, 1'b1, 4'b1001, 5);
    chk("rotate_after_bp", 32'(req_ready), 32'h8);
    req_valid = '0;
    tick();
    chk("withdrawn_idle", 32'(busy), 32'd0);

    // async reset in EXEC discards the transaction
    set_ops(2, 8'h00, 8'h01, 8'h01);
    req_valid[2] = 1'b1;
    #1;
    chk("pre_reset_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_alu_opcode", 32'(alu_opcode), 32'hFF);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_state", 32'(dbg_state), 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("no_ghost_rsp", 32'(rsp_valid), 32'd0);
    end
    set_ops(0, 8'h00, 8'h20, 8'h22);
    req_valid = 4'b1111;
    exp_q.push_back({1'b0, 5'b00000, 8'h42});
    run_txn(0, 8'h00, 8'h20, 8'h22, 1'b1, '0, 0);
    req_valid = '0;

    // req1 withdraws before grant, req3 wins: 0xFF + 0x01 -> 0x00, zero/carry
    set_ops(1, 8'h00, 8'h11, 8'h11);
    req_valid[1] = 1'b1;
    #1;
    chk("req1_offered", 32'(req_ready), 32'h2);
    req_valid[1] = 1'b0;
    set_ops(3, 8'h00, 8'hFF, 8'h01);
    req_valid[3] = 1'b1;
    exp_q.push_back({1'b0, 5'b00011, 8'h00});
    run_txn(3, 8'h00, 8'hFF, 8'h01, 1'b1, '0, 0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
